seq_detect_fsm: RTL and testbench
=================================

// Module: seq_detect_fsm
// PURPOSE
// - Parametrised Mealy serial-pattern detector; next generation of the team's 2-bit hand-coded Mealy FSMs.
// - Watches a 1-bit serial stream and raises a match pulse when the last W accepted bits equal PATTERN.
// - Pattern width, pattern value and overlap mode are set by parameters; bits are qualified by an enable.
// - Exposes current state s and next state n for debug and for the lab bench.
// PARAMETERS
// - W        4        pattern length in bits; legal range 2..16
// - PATTERN  4'b1011  pattern bits, W wide; MSB is the first bit received
// - OVERLAP  1        1: overlapping matches count; 0: after a match, detection restarts from empty
// - CNT_W    8        match counter width; used only when SEQDET_MATCH_COUNT_EN is defined
// PORTS
// - clk        in   1       clock; all state changes on the rising edge
// - reset      in   1       synchronous, active-high reset
// - en         in   1       x is valid this cycle; a bit is accepted only when en=1
// - clr        in   1       synchronous clear of the detection history; does not clear match_cnt
// - x          in   1       serial data bit
// - y          out  1       match, combinational (Mealy): 1 in the cycle the completing bit is accepted
// - n          out  SW      next state, combinational; SW = $clog2(W+1)
// - s          out  SW      current state, registered
// - match_cnt  out  CNT_W   saturating match count; present only with SEQDET_MATCH_COUNT_EN
// BEHAVIOUR
// Internal state
// - h: history register, W-1 bits, holding the last accepted bits.
// - f: fill count, 0..W-1, giving the number of valid bits in h.
// State and next-state definition
// - s = length of the longest prefix of PATTERN that is a suffix of the accepted bits since the last restart.
// - With en=1: c = {h[f-1:0], x}, length f+1. n = largest k <= min(f+1, W) with c[k-1:0] == PATTERN[W-1:W-k].
// - n = 0 when no such k exists.
// - With en=0, or with clr=1: n = 0 if clr=1, else n = s.
// Output
// - y = en & ~clr & ~reset & (n == W).
// Clock edge, in priority order
// - reset, then clr: s=0, h=0, f=0. Any en bit in that cycle is discarded.
// - Otherwise, with en=1: h <= {h, x} truncated to W-1 bits; f <= min(f+1, W-1); s <= n.
// - Match with OVERLAP=0 overrides the above: s <= 0, f <= 0, h <= 0.
// - Match with OVERLAP=1: s <= W. The next bit falls back through the history as defined above.
// - en=0: all registers hold.
// Reset values
// - s=0, h=0, f=0, match_cnt=0.
// - y=0 and n=0 while reset=1.
// Latency
// - y is asserted in the same cycle as the completing bit; s reflects that bit one edge later.
// Boundary conditions
// - Partial fill: a match requires f+1 >= W, so no match is possible before W bits have been accepted.
// - f saturates at W-1.
// - PATTERN all ones or all zeros with OVERLAP=1: a match on every bit after the first W.
// CONFIGURATION
// - Macro SEQDET_MATCH_COUNT_EN.
// - Defined: adds the match_cnt port. It increments on every cycle with y=1 and saturates at all-ones.
// - match_cnt is cleared only by reset, not by clr.
// - Undefined: no match_cnt port and no counter logic. All other behaviour is identical.
// TESTING
// All scenarios use W=4 and PATTERN=4'b1011 unless stated; en=1 on every bit.
// - T1 overlap (OVERLAP=1): x = 1,0,1,1,0,1,1 -> s after each bit = 1,2,3,4,2,3,4; y=1 on bits 4 and 7 only.
// - T2 non-overlap (OVERLAP=0): x = 1,0,1,1,0,1,1 -> s = 1,2,3,0,0,1,1; y=1 on bit 4 only.
// - T3 enable gaps: x = 1,0,1 then en=0 for 3 cycles with x toggling, then x=1 -> s holds 3 and y=0 during the gap; y=1 on the final bit.
// - T4 saturating pattern (PATTERN=4'b1111, OVERLAP=1): x = 1,1,1,1,1,1 -> y=1 on bits 4, 5 and 6.
//   Same stream with OVERLAP=0 -> y=1 on bit 4 only.
// - T5 reset and clr mid-stream: x = 1,0,1, then reset=1 for one cycle with en=1 and x=1 -> s=0 and y=0 in that cycle.
//   Then x = 1,0,1,1 -> y=1 on its 4th bit.
//   Repeat the same sequence with clr in place of reset -> identical response.
// - T6 counter (SEQDET_MATCH_COUNT_EN, CNT_W=2, OVERLAP=1): x = 1,0,1,1,0,1,1,0,1,1,0,1,1 (4 matches) -> match_cnt = 1,2,3,3.
//   A clr pulse leaves match_cnt at 3; reset sets it to 0.

Source files
------------

// File: rtl/seq_detect_fsm.sv
// Parametrised Mealy serial-pattern detector with debug state (s) and next state (n).
// Optional saturating match counter enabled by defining SEQDET_MATCH_COUNT_EN.
module seq_detect_fsm #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8,
  localparam int            SW      = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  input  logic          x,
  output logic          y,
  output logic [SW-1:0] n,
  output logic [SW-1:0] s
`ifdef SEQDET_MATCH_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam logic [SW-1:0] F_MAX = SW'(W - 1);
  localparam logic [SW-1:0] S_MAX = SW'(W);

  logic [W-2:0]  h;
  logic [SW-1:0] f;
  logic [W-1:0]  c_vec;
  logic [SW-1:0] n_calc;

  // Newest bit sits at c_vec[0]; bits above f are ignored by the fill guard.
  assign c_vec = {h, x};

  always_comb begin
    n_calc = '0;
    for (int k = 1; k <= W; k++) begin
      if ((k <= int'(f) + 1) &&
          ((((c_vec ^ (PATTERN >> (W - k))) & ({W{1'b1}} >> (W - k))) == '0)))
        n_calc = SW'(k);
    end
  end

  always_comb begin
    if (reset || clr) n = '0;
    else if (en)      n = n_calc;
    else              n = s;
  end

  assign y = en & ~clr & ~reset & (n == S_MAX);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      s <= '0;
      h <= '0;
      f <= '0;
    end else if (en) begin
      if (y && !OVERLAP) begin
        s <= '0;
        h <= '0;
        f <= '0;
      end else begin
        s <= n;
        h <= c_vec[W-2:0];
        f <= (f == F_MAX) ? f : f + 1'b1;
      end
    end
  end

`ifdef SEQDET_MATCH_COUNT_EN
  // Counter survives clr; only reset returns it to zero.
  always_ff @(posedge clk) begin
    if (reset)                          match_cnt <= '0;
    else if (y && (match_cnt != '1))    match_cnt <= match_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Bench for seq_detect_fsm: four instances (1011/1111 x overlap/non-overlap) share one stimulus stream,
// checked against directed tables and a stream-history reference model under random stimulus.
module tb_seq_detect_fsm;

  logic       clk = 1'b0;
  logic       reset, en, clr, x;
  logic       y_w[4];
  logic [2:0] n_w[4];
  logic [2:0] s_w[4];
  logic [1:0] cnt_w[4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_detect_fsm #(.W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) d0 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .x(x), .y(y_w[0]), .n(n_w[0]), .s(s_w[0])
`ifdef SEQDET_MATCH_COUNT_EN
    , .match_cnt(cnt_w[0])
`endif
  );
  seq_detect_fsm #(.W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(2)) d1 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .x(x), .y(y_w[1]), .n(n_w[1]), .s(s_w[1])
`ifdef SEQDET_MATCH_COUNT_EN
    , .match_cnt(cnt_w[1])
`endif
  );
  seq_detect_fsm #(.W(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) d2 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .x(x), .y(y_w[2]), .n(n_w[2]), .s(s_w[2])
`ifdef SEQDET_MATCH_COUNT_EN
    , .match_cnt(cnt_w[2])
`endif
  );
  seq_detect_fsm #(.W(4), .PATTERN(4'b1111), .OVERLAP(1'b0), .CNT_W(2)) d3 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .x(x), .y(y_w[3]), .n(n_w[3]), .s(s_w[3])
`ifdef SEQDET_MATCH_COUNT_EN
    , .match_cnt(cnt_w[3])
`endif
  );

  // Reference model: accepted bits since the last restart, newest in bit 0.
  logic [3:0]  pat_m[4];
  bit          ov_m[4];
  logic [31:0] mh[4];
  int          ml[4];
  int          cnt_m;

  function automatic int lps(input logic [31:0] h, input int len, input logic [3:0] pat);
    int top;
    bit ok;
    top = (len < 4) ? len : 4;
    for (int k = top; k >= 1; k--) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++)
        if (h[k-1-i] != pat[3-i]) ok = 1'b0;
      if (ok) return k;
    end
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive, compare in-cycle outputs, advance model, wait for next negedge.
  task automatic step(input bit r, input bit c, input bit e, input bit xb, output bit [3:0] ys);
    int s_exp, n_exp;
    bit [3:0] y_exp;
    reset = r; clr = c; en = e; x = xb;
    #2;
    for (int d = 0; d < 4; d++) begin
      s_exp = lps(mh[d], ml[d], pat_m[d]);
      if (r || c)  n_exp = 0;
      else if (e)  n_exp = lps({mh[d][30:0], xb}, ml[d] + 1, pat_m[d]);
      else         n_exp = s_exp;
      y_exp[d] = e && !c && !r && (n_exp == 4);
      chk($sformatf("d%0d_s", d), 32'(s_w[d]), 32'(s_exp));
      chk($sformatf("d%0d_n", d), 32'(n_w[d]), 32'(n_exp));
      chk($sformatf("d%0d_y", d), 32'(y_w[d]), 32'(y_exp[d]));
      ys[d] = y_w[d];
    end
`ifdef SEQDET_MATCH_COUNT_EN
    chk("d0_cnt", 32'(cnt_w[0]), 32'(cnt_m));
`endif
    for (int d = 0; d < 4; d++) begin
      if (r || c) begin
        mh[d] = '0; ml[d] = 0;
      end else if (e) begin
        mh[d] = {mh[d][30:0], xb};
        ml[d] = (ml[d] < 16) ? ml[d] + 1 : 16;
        if (y_exp[d] && !ov_m[d]) begin
          mh[d] = '0; ml[d] = 0;
        end
      end
    end
    if (r) cnt_m = 0;
    else if (y_exp[0] && cnt_m < 3) cnt_m++;
    @(negedge clk);
  endtask

  typedef struct {
    bit       r, c, e, x;
    bit [3:0] y;   // {d3,d2,d1,d0}
    int       s0, s1;
  } vec_t;

  vec_t tbl[39];

  initial begin
    bit [3:0] ys;
    logic [12:0] t6_seq;
    pat_m = '{4'b1011, 4'b1011, 4'b1111, 4'b1111};
    ov_m  = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int d = 0; d < 4; d++) begin
      mh[d] = '0; ml[d] = 0;
    end
    cnt_m = 0;

    tbl[0]  = '{1,0,0,0, 4'b0000, 0, 0};
    // Overlap vs non-overlap on 1,0,1,1,0,1,1
    tbl[1]  = '{0,0,1,1, 4'b0000, 1, 1};
    tbl[2]  = '{0,0,1,0, 4'b0000, 2, 2};
    tbl[3]  = '{0,0,1,1, 4'b0000, 3, 3};
    tbl[4]  = '{0,0,1,1, 4'b0011, 4, 0};
    tbl[5]  = '{0,0,1,0, 4'b0000, 2, 0};
    tbl[6]  = '{0,0,1,1, 4'b0000, 3, 1};
    tbl[7]  = '{0,0,1,1, 4'b0001, 4, 1};
    // Saturating 1111 pattern on six ones
    tbl[8]  = '{0,1,1,1, 4'b0000, 0, 0};
    tbl[9]  = '{0,0,1,1, 4'b0000, 1, 1};
    tbl[10] = '{0,0,1,1, 4'b0000, 1, 1};
    tbl[11] = '{0,0,1,1, 4'b0000, 1, 1};
    tbl[12] = '{0,0,1,1, 4'b1100, 1, 1};
    tbl[13] = '{0,0,1,1, 4'b0100, 1, 1};
    tbl[14] = '{0,0,1,1, 4'b0100, 1, 1};
    // Enable gap holds state
    tbl[15] = '{0,1,1,0, 4'b0000, 0, 0};
    tbl[16] = '{0,0,1,1, 4'b0000, 1, 1};
    tbl[17] = '{0,0,1,0, 4'b0000, 2, 2};
    tbl[18] = '{0,0,1,1, 4'b0000, 3, 3};
    tbl[19] = '{0,0,0,1, 4'b0000, 3, 3};
    tbl[20] = '{0,0,0,0, 4'b0000, 3, 3};
    tbl[21] = '{0,0,0,1, 4'b0000, 3, 3};
    tbl[22] = '{0,0,1,1, 4'b0011, 4, 0};
    // Reset mid-stream, then clr mid-stream
    tbl[23] = '{0,0,1,1, 4'b0000, 1, 1};
    tbl[24] = '{0,0,1,0, 4'b0000, 2, 2};
    tbl[25] = '{0,0,1,1, 4'b0000, 3, 3};
    tbl[26] = '{1,0,1,1, 4'b0000, 0, 0};
    tbl[27] = '{0,0,1,1, 4'b0000, 1, 1};
    tbl[28] = '{0,0,1,0, 4'b0000, 2, 2};
    tbl[29] = '{0,0,1,1, 4'b0000, 3, 3};
    tbl[30] = '{0,0,1,1, 4'b0011, 4, 0};
    tbl[31] = '{0,0,1,1, 4'b0000, 1, 1};
    tbl[32] = '{0,0,1,0, 4'b0000, 2, 2};
    tbl[33] = '{0,0,1,1, 4'b0000, 3, 3};
    tbl[34] = '{0,1,1,1, 4'b0000, 0, 0};
    tbl[35] = '{0,0,1,1, 4'b0000, 1, 1};
    tbl[36] = '{0,0,1,0, 4'b0000, 2, 2};
    tbl[37] = '{0,0,1,1, 4'b0000, 3, 3};
    tbl[38] = '{0,0,1,1, 4'b0011, 4, 0};

    // Clock/reset: bring registers out of X before any comparison.
    reset = 1'b1; clr = 1'b0; en = 1'b0; x = 1'b0;
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < 39; i++) begin
      step(tbl[i].r, tbl[i].c, tbl[i].e, tbl[i].x, ys);
      chk($sformatf("tbl%0d_y", i), 32'(ys), 32'(tbl[i].y));
      chk($sformatf("tbl%0d_s0", i), 32'(s_w[0]), 32'(tbl[i].s0));
      chk($sformatf("tbl%0d_s1", i), 32'(s_w[1]), 32'(tbl[i].s1));
    end

`ifdef SEQDET_MATCH_COUNT_EN
    // Saturating counter: four matches on a 2-bit counter, survives clr, cleared by reset.
    step(1, 0, 0, 0, ys);
    chk("cnt_reset", 32'(cnt_w[0]), 32'd0);
    t6_seq = 13'b1011011011011;
    for (int i = 12; i >= 0; i--) begin
      step(0, 0, 1, t6_seq[i], ys);
      if (i == 9) chk("cnt_m1", 32'(cnt_w[0]), 32'd1);
      if (i == 6) chk("cnt_m2", 32'(cnt_w[0]), 32'd2);
      if (i == 3) chk("cnt_m3", 32'(cnt_w[0]), 32'd3);
      if (i == 0) chk("cnt_m4", 32'(cnt_w[0]), 32'd3);
    end
    step(0, 1, 0, 0, ys);
    chk("cnt_after_clr", 32'(cnt_w[0]), 32'd3);
    step(1, 0, 0, 0, ys);
    chk("cnt_after_reset", 32'(cnt_w[0]), 32'd0);
`else
    t6_seq = '0;
`endif

    // Random stream against the reference model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 65, ys);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
